// File: rtl/guess_autoplayer.sv
// Automated player for the guess game: waits for the chosen LED, presses a button,
// waits for the verdict, releases the buttons and tallies wins and losses.
module guess_autoplayer #(
    parameter int TIMEOUT        = 1024,
    parameter int RELEASE_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       target,
    input  logic             miss,
    input  logic [3:0]       y,
    input  logic             win,
    input  logic             lose,
    output logic [3:0]       b,
    output logic             busy,
    output logic             done,
    output logic             result_win,
    output logic             timeout,
    output logic [CNT_W-1:0] win_count,
    output logic [CNT_W-1:0] lose_count
);

    localparam int TMAX = (TIMEOUT > RELEASE_CYCLES) ? TIMEOUT : RELEASE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    REL_LAST   = TW'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SEEK, PRESS, RELEASE} state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [3:0]       tgt, tgt_nx;
    logic             miss_q, miss_nx;
    logic [3:0]       b_nx;
    logic             busy_nx, done_nx, result_nx, timeout_nx;
    logic [CNT_W-1:0] win_nx, lose_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            tgt        <= '0;
            miss_q     <= 1'b0;
            b          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_win <= 1'b0;
            timeout    <= 1'b0;
            win_count  <= '0;
            lose_count <= '0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            tgt        <= tgt_nx;
            miss_q     <= miss_nx;
            b          <= b_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            result_win <= result_nx;
            timeout    <= timeout_nx;
            win_count  <= win_nx;
            lose_count <= lose_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && $onehot(target)) state_nx = SEEK;
            SEEK: begin
                if (y == tgt)                 state_nx = PRESS;
                else if (timer == TIMER_LAST) state_nx = RELEASE;
            end
            PRESS:   if (win || lose || timer == TIMER_LAST) state_nx = RELEASE;
            RELEASE: if (timer >= REL_LAST && !win && !lose) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Everything below computes the values the output registers take at the next edge.
    always_comb begin
        tgt_nx     = tgt;
        miss_nx    = miss_q;
        b_nx       = b;
        busy_nx    = busy;
        done_nx    = 1'b0;
        result_nx  = result_win;
        timeout_nx = timeout;
        win_nx     = win_count;
        lose_nx    = lose_count;
        if (state_nx != state)  timer_nx = '0;
        else if (timer == '1)   timer_nx = timer;
        else                    timer_nx = timer + TW'(1);

        case (state)
            IDLE: begin
                b_nx = '0;
                if (state_nx == SEEK) begin
                    tgt_nx     = target;
                    miss_nx    = miss;
                    timeout_nx = 1'b0;
                    busy_nx    = 1'b1;
                end
            end
            SEEK: begin
                if (y == tgt) begin
                    b_nx = miss_q ? {y[2:0], y[3]} : y;
                end else if (timer == TIMER_LAST) begin
                    timeout_nx = 1'b1;
                    result_nx  = 1'b0;
                end
            end
            PRESS: begin
                // lose outranks win when the game reports both
                if (lose) begin
                    result_nx = 1'b0;
                    if (lose_count != CNT_MAX) lose_nx = lose_count + CNT_W'(1);
                end else if (win) begin
                    result_nx = 1'b1;
                    if (win_count != CNT_MAX) win_nx = win_count + CNT_W'(1);
                end else if (timer == TIMER_LAST) begin
                    timeout_nx = 1'b1;
                    result_nx  = 1'b0;
                end
                if (state_nx == RELEASE) b_nx = '0;
            end
            RELEASE: begin
                b_nx = '0;
                if (state_nx == IDLE) begin
                    done_nx = 1'b1;
                    busy_nx = 1'b0;
                end
            end
            default: b_nx = '0;
        endcase
    end

endmodule

// File: doc/guess_autoplayer.md
Name: guess_autoplayer

Overview:
- Automated player for the guess game. It is the driving end of the game's button/LED interface.
- It watches the one-hot LED pattern y, presses button vector b on a chosen slot, and waits for the game's win/lose verdict.
- It then releases the buttons and tallies results.
- It sits beside guess_FSM, replacing the physical buttons in demo/self-test mode, with b wired to guess_FSM.b and y/win/lose wired back.

Parameters:
- TIMEOUT, 1024: max cycles spent in SEEK or PRESS before abort.
- RELEASE_CYCLES, 4: minimum cycles b is held at 0 after a verdict.
- CNT_W, 8: width of the win and loss counters.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  single-cycle request to play one round
- target  input  4  one-hot LED slot to act on
- miss  input  1  1 = deliberately press the wrong button
- y  input  4  one-hot LED pattern from the game
- win  input  1  game win indication
- lose  input  1  game lose indication
- b  output  4  button vector to the game
- busy  output  1  round in progress
- done  output  1  one-cycle pulse when a round ends
- result_win  output  1  verdict of the last completed round
- timeout  output  1  sticky abort flag
- win_count  output  CNT_W  saturating count of wins
- lose_count  output  CNT_W  saturating count of losses

Behaviour:
- All outputs are registered. Reset values: b=0, busy=0, done=0, result_win=0, timeout=0, win_count=0, lose_count=0, state=IDLE, timer=0.
- Reset asserted mid-round aborts immediately: the next edge gives reset values and no done pulse.
- States are IDLE, SEEK, PRESS, RELEASE.
- IDLE:
  - b=0.
  - start=1 with target having exactly one bit set: latch target and miss, clear timeout and timer, go to SEEK; busy=1 from the next cycle.
  - start with an invalid target (0 bits or more than 1 bit set) is ignored.
  - start while busy is ignored.
- SEEK:
  - Each cycle compare y against the latched target.
  - On a match: b <= (miss ? {y[2:0],y[3]} : y), timer cleared, go to PRESS. b is visible the cycle after the match.
  - win/lose are ignored in SEEK.
  - If timer reaches TIMEOUT-1 without a match: timeout=1, go to RELEASE with no count change, and result_win=0.
- PRESS:
  - b is held constant.
  - win=1 and lose=0: result_win=1, win_count+1, go to RELEASE.
  - lose=1 (with or without win): lose has priority; result_win=0, lose_count+1, go to RELEASE.
  - If timer reaches TIMEOUT-1 without a verdict: timeout=1, no count change, go to RELEASE.
- RELEASE:
  - b=0.
  - Stay until at least RELEASE_CYCLES cycles have elapsed AND win=0 AND lose=0.
  - Then done=1 for exactly one cycle, busy=0 in the same cycle, go to IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap. They are cleared only by reset.
- Minimum round length from start to done: 1 (accept) + 1 (SEEK match) + 1 (verdict) + RELEASE_CYCLES.
- timer is wide enough for TIMEOUT, and resets on every state change.

Test Plan:
- Hit: reset, then start with target=4'b0100, miss=0; game model rotates y one position per 4 cycles and asserts win 2 cycles after b==y. Required: b=4'b0100 only while in PRESS; done pulse once; result_win=1; win_count=1; lose_count=0; timeout=0.
- Miss: start with target=4'b0001, miss=1. Required: b=4'b0010 when y=4'b0001; model asserts lose; result_win=0; lose_count=1; b returns to 0 for at least 4 cycles before done.
- Timeout: start with target=4'b1000 while y is stuck at 4'b0001 (TIMEOUT set to 16). Required: timeout=1 at 16 cycles after entering SEEK; done pulses; counters unchanged. The next valid start clears timeout.
- Invalid and ignored starts: start with target=4'b0110, then with 4'b0000, then a second start during a busy round. Required: busy stays 0 for the invalid targets; the mid-round start does not alter the latched target or produce an extra done.
- Release hold: after a verdict, the model holds win=1 for 10 cycles. Required: done is delayed until win drops, with b=0 throughout. Simultaneous win=1 and lose=1 counts as a loss.
- Saturation and reset: with CNT_W=2, play 5 winning rounds. Required: win_count=3 and stays 3. Assert reset mid-PRESS: next cycle all outputs are at reset values with no done pulse.
